// File: rtl/i2c_cfg_sequencer.sv
// Walks a {dev, sub, data} table in sync ROM, issuing I2C writes with optional readback/retry.
// One transaction in flight; requests wait for i2c_busy low, each busy phase is timeout-guarded.
module i2c_cfg_sequencer #(
   parameter int ROM_AW    = 6,
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 4096,
   parameter int VERIFY_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_q,
   output logic [7:0]        i_addr_w_rw,
   output logic [7:0]        i_sub_addr,
   output logic [7:0]        i_data_write,
   output logic              req_trans,
   input  logic              i2c_busy,
   input  logic [7:0]        i2c_data_out,
   input  logic              i2c_valid_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ROM_AW-1:0] err_index,
   output logic [ROM_AW-1:0] entry_cnt
);
   localparam int BW   = ROM_AW + 2;
   localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int AT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [BW-1:0] ROM_TOP = BW'((1 << ROM_AW) - 1);

   typedef enum logic [3:0] {
      IDLE, FETCH0, FETCH1, FETCH2, ISSUE_W, WAIT_HI, WAIT_LO,
      ISSUE_R, WAIT_RHI, WAIT_RLO, CHECK, NEXT, DONE, ERROR
   } state_t;

   state_t            state;
   logic [BW-1:0]     base;
   logic [BW-1:0]     base_nxt;
   logic [ROM_AW-1:0] idx;
   logic [6:0]        dev7;
   logic [7:0]        rd_dat;
   logic              rd_vld;
   logic              fetch_wait;
   logic [TW-1:0]     tmo;
   logic [AT_W-1:0]   attempt;
   logic              in_wait;
   logic              wait_exit;
   logic              tmo_fail;

   assign base_nxt  = base + BW'(3);
   assign in_wait   = state inside {WAIT_HI, WAIT_LO, WAIT_RHI, WAIT_RLO};
   assign wait_exit = (state == WAIT_HI || state == WAIT_RHI) ? i2c_busy : !i2c_busy;
   assign tmo_fail  = in_wait && !wait_exit && (tmo == TW'(TIMEOUT - 1));
   assign busy      = !(state inside {IDLE, DONE, ERROR});

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         base         <= '0;
         idx          <= '0;
         dev7         <= '0;
         rd_dat       <= '0;
         rd_vld       <= 1'b0;
         fetch_wait   <= 1'b0;
         tmo          <= '0;
         attempt      <= '0;
         rom_addr     <= '0;
         i_addr_w_rw  <= '0;
         i_sub_addr   <= '0;
         i_data_write <= '0;
         req_trans    <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= 2'b00;
         err_index    <= '0;
         entry_cnt    <= '0;
      end else begin
         req_trans <= 1'b0;
         if (in_wait)
            tmo <= tmo + TW'(1);
         if ((state == WAIT_RHI || state == WAIT_RLO) && i2c_valid_out) begin
            rd_dat <= i2c_data_out;
            rd_vld <= 1'b1;
         end
         if (tmo_fail) begin
            state     <= ERROR;
            error     <= 1'b1;
            err_code  <= 2'b10;
            err_index <= idx;
         end else begin
            case (state)
               IDLE, DONE, ERROR: begin
                  if (start) begin
                     state      <= FETCH0;
                     fetch_wait <= 1'b0;
                     base       <= '0;
                     idx        <= '0;
                     rom_addr   <= '0;
                     attempt    <= '0;
                     entry_cnt  <= '0;
                     done       <= 1'b0;
                     error      <= 1'b0;
                     err_code   <= 2'b00;
                     err_index  <= '0;
                  end
               end
               // Each fetch spends one cycle letting the ROM register the address.
               FETCH0: begin
                  fetch_wait <= !fetch_wait;
                  if (fetch_wait) begin
                     dev7 <= rom_q[7:1];
                     if (rom_q == 8'hFF) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        rom_addr <= base[ROM_AW-1:0] + ROM_AW'(1);
                        state    <= FETCH1;
                     end
                  end
               end
               FETCH1: begin
                  fetch_wait <= !fetch_wait;
                  if (fetch_wait) begin
                     i_sub_addr <= rom_q;
                     rom_addr   <= base[ROM_AW-1:0] + ROM_AW'(2);
                     state      <= FETCH2;
                  end
               end
               FETCH2: begin
                  fetch_wait <= !fetch_wait;
                  if (fetch_wait) begin
                     i_data_write <= rom_q;
                     state        <= ISSUE_W;
                  end
               end
               ISSUE_W: begin
                  if (!i2c_busy) begin
                     i_addr_w_rw <= {dev7, 1'b0};
                     req_trans   <= 1'b1;
                     tmo         <= '0;
                     state       <= WAIT_HI;
                  end
               end
               WAIT_HI: begin
                  if (i2c_busy) begin
                     tmo   <= '0;
                     state <= WAIT_LO;
                  end
               end
               WAIT_LO: begin
                  if (!i2c_busy)
                     state <= (VERIFY_EN != 0) ? ISSUE_R : NEXT;
               end
               ISSUE_R: begin
                  if (!i2c_busy) begin
                     i_addr_w_rw <= {dev7, 1'b1};
                     req_trans   <= 1'b1;
                     rd_vld      <= 1'b0;
                     tmo         <= '0;
                     state       <= WAIT_RHI;
                  end
               end
               WAIT_RHI: begin
                  if (i2c_busy) begin
                     tmo   <= '0;
                     state <= WAIT_RLO;
                  end
               end
               WAIT_RLO: begin
                  if (!i2c_busy)
                     state <= CHECK;
               end
               // A read that never strobed valid counts as a mismatch.
               CHECK: begin
                  if (rd_vld && rd_dat == i_data_write) begin
                     state <= NEXT;
                  end else if (attempt < AT_W'(MAX_RETRY)) begin
                     attempt <= attempt + AT_W'(1);
                     state   <= ISSUE_W;
                  end else begin
                     state     <= ERROR;
                     error     <= 1'b1;
                     err_code  <= 2'b01;
                     err_index <= idx;
                  end
               end
               NEXT: begin
                  entry_cnt  <= entry_cnt + ROM_AW'(1);
                  idx        <= idx + ROM_AW'(1);
                  attempt    <= '0;
                  base       <= base_nxt;
                  rom_addr   <= base_nxt[ROM_AW-1:0];
                  fetch_wait <= 1'b0;
                  if (base_nxt + BW'(2) > ROM_TOP) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: write-only and verifying instances share one ROM table,
// one I2C master model and one transaction scoreboard.
module tb_i2c_cfg_sequencer;
   localparam int BUSY_CYC = 20;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] s;
      logic [7:0] d;
   } txn_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b, sel;
   logic [5:0] rom_addr_a, rom_addr_b;
   logic [7:0] rom_q_a, rom_q_b;
   logic [7:0] a_addr, a_sub, a_wdat, b_addr, b_sub, b_wdat;
   logic       a_req, a_busy, a_done, a_error, b_req, b_busy, b_done, b_error;
   logic [1:0] a_ec, b_ec;
   logic [5:0] a_ei, a_cnt, b_ei, b_cnt;
   logic       i2c_busy, i2c_valid_out;
   logic [7:0] i2c_data_out;

   logic [7:0] m_addr, m_sub, m_wdat;
   logic       m_req, m_busy, m_done, m_error;
   logic [1:0] m_ec;
   logic [5:0] m_ei, m_cnt, m_rom_addr;

   logic [7:0] rom [64];
   txn_t       exp_q [$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_req_cyc = 0;
   int         rd_cnt = 0;
   int         rd_base = 0;
   int         bad_limit = 0;
   logic       no_busy = 1'b0;
   logic       prev_req = 1'b0;

   always #5 clk = ~clk;

   i2c_cfg_sequencer #(.ROM_AW(6), .MAX_RETRY(2), .TIMEOUT(64), .VERIFY_EN(0)) u_dut_wo (
      .clk(clk), .reset(reset), .start(start_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
      .i_addr_w_rw(a_addr), .i_sub_addr(a_sub), .i_data_write(a_wdat), .req_trans(a_req),
      .i2c_busy(i2c_busy), .i2c_data_out(i2c_data_out), .i2c_valid_out(i2c_valid_out),
      .busy(a_busy), .done(a_done), .error(a_error), .err_code(a_ec), .err_index(a_ei),
      .entry_cnt(a_cnt));

   i2c_cfg_sequencer #(.ROM_AW(6), .MAX_RETRY(2), .TIMEOUT(64), .VERIFY_EN(1)) u_dut_vf (
      .clk(clk), .reset(reset), .start(start_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
      .i_addr_w_rw(b_addr), .i_sub_addr(b_sub), .i_data_write(b_wdat), .req_trans(b_req),
      .i2c_busy(i2c_busy), .i2c_data_out(i2c_data_out), .i2c_valid_out(i2c_valid_out),
      .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_ec), .err_index(b_ei),
      .entry_cnt(b_cnt));

   assign m_addr     = sel ? b_addr : a_addr;
   assign m_sub      = sel ? b_sub : a_sub;
   assign m_wdat     = sel ? b_wdat : a_wdat;
   assign m_req      = sel ? b_req : a_req;
   assign m_busy     = sel ? b_busy : a_busy;
   assign m_done     = sel ? b_done : a_done;
   assign m_error    = sel ? b_error : a_error;
   assign m_ec       = sel ? b_ec : a_ec;
   assign m_ei       = sel ? b_ei : a_ei;
   assign m_cnt      = sel ? b_cnt : a_cnt;
   assign m_rom_addr = sel ? rom_addr_b : rom_addr_a;

   initial forever begin
      @(posedge clk);
      rom_q_a <= rom[rom_addr_a];
      rom_q_b <= rom[rom_addr_b];
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Master model: busy for BUSY_CYC cycles per request; reads return the last written
   // byte, or 0x00 for the first bad_limit reads counted from rd_base.
   initial begin
      logic       is_rd;
      logic [7:0] last_wr;
      last_wr       = 8'h00;
      i2c_busy      = 1'b0;
      i2c_valid_out = 1'b0;
      i2c_data_out  = 8'h00;
      forever begin
         @(negedge clk);
         if (m_req && !no_busy && !reset) begin
            is_rd = m_addr[0];
            if (!is_rd) last_wr = m_wdat;
            i2c_busy = 1'b1;
            for (int k = 0; k < BUSY_CYC; k++) begin
               @(negedge clk);
               i2c_valid_out = 1'b0;
               if (is_rd && k == 10) begin
                  i2c_valid_out = 1'b1;
                  i2c_data_out  = (rd_cnt - rd_base < bad_limit) ? 8'h00 : last_wr;
                  rd_cnt++;
               end
            end
            i2c_valid_out = 1'b0;
            i2c_busy      = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every request pulse must match the next expected transaction.
   initial forever begin
      txn_t e;
      @(posedge clk);
      #1;
      if (m_req) begin
         last_req_cyc = cyc;
         check("req_while_busy", i2c_busy, 1'b0);
         check("req_one_cycle", prev_req, 1'b0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got %h/%h/%h, expected none", m_addr, m_sub, m_wdat);
         end else begin
            e = exp_q.pop_front();
            check("txn_dev", m_addr, e.a);
            check("txn_sub", m_sub, e.s);
            check("txn_data", m_wdat, e.d);
         end
      end
      prev_req = m_req;
   end

   task automatic push(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d);
      txn_t t;
      t.a = a;
      t.s = s;
      t.d = d;
      exp_q.push_back(t);
   endtask

   task automatic push_entry(input logic [7:0] s, input logic [7:0] d, input bit rd);
      push(8'hB8, s, d);
      if (rd) push(8'hB9, s, d);
   endtask

   task automatic pulse_start(input logic which_b);
      @(negedge clk);
      sel = which_b;
      start_a = !which_b;
      start_b = which_b;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_end(input string name, input int budget, output int ecyc);
      int n;
      n = 0;
      ecyc = -1;
      while (n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (m_done || m_error) begin
            ecyc = cyc;
            break;
         end
      end
      if (ecyc < 0) begin
         tests++;
         fails++;
         $display("FAIL %s_wait: got no done/error, expected one within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_busy(input logic lvl, input int budget);
      int n;
      n = 0;
      while (i2c_busy !== lvl && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_i2c_busy", i2c_busy, lvl);
   endtask

   initial begin
      int ecyc;
      int n;
      reset = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      sel = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = 8'hFF;
      rom[0] = 8'hB8; rom[1] = 8'h03; rom[2] = 8'h6F;
      rom[3] = 8'hB8; rom[4] = 8'h0F; rom[5] = 8'h02;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", m_busy, 1'b0);
      check("rst_done", m_done, 1'b0);
      check("rst_error", m_error, 1'b0);
      check("rst_err_code", m_ec, 2'b00);
      check("rst_entry_cnt", m_cnt, 6'd0);
      check("rst_req", m_req, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Write-only walk.
      sel = 1'b0;
      push_entry(8'h03, 8'h6F, 1'b0);
      push_entry(8'h0F, 8'h02, 1'b0);
      pulse_start(1'b0);
      wait_end("wo", 2000, ecyc);
      check("wo_done", m_done, 1'b1);
      check("wo_error", m_error, 1'b0);
      check("wo_entry_cnt", m_cnt, 6'd2);
      check("wo_q_empty", exp_q.size(), 0);

      // Verified walk with echo readback.
      rd_base = rd_cnt;
      bad_limit = 0;
      push_entry(8'h03, 8'h6F, 1'b1);
      push_entry(8'h0F, 8'h02, 1'b1);
      pulse_start(1'b1);
      wait_end("vf", 2000, ecyc);
      check("vf_done", m_done, 1'b1);
      check("vf_error", m_error, 1'b0);
      check("vf_entry_cnt", m_cnt, 6'd2);
      check("vf_q_empty", exp_q.size(), 0);

      // One bad readback on entry 0 costs exactly one retry.
      rd_base = rd_cnt;
      bad_limit = 1;
      push_entry(8'h03, 8'h6F, 1'b1);
      push_entry(8'h03, 8'h6F, 1'b1);
      push_entry(8'h0F, 8'h02, 1'b1);
      pulse_start(1'b1);
      wait_end("retry1", 3000, ecyc);
      check("retry1_done", m_done, 1'b1);
      check("retry1_error", m_error, 1'b0);
      check("retry1_entry_cnt", m_cnt, 6'd2);
      check("retry1_q_empty", exp_q.size(), 0);

      // Persistent mismatch: three attempts then verify error.
      rd_base = rd_cnt;
      bad_limit = 100;
      for (int i = 0; i < 3; i++) push_entry(8'h03, 8'h6F, 1'b1);
      pulse_start(1'b1);
      wait_end("mism", 3000, ecyc);
      check("mism_error", m_error, 1'b1);
      check("mism_done", m_done, 1'b0);
      check("mism_err_code", m_ec, 2'b01);
      check("mism_err_index", m_ei, 6'd0);
      check("mism_entry_cnt", m_cnt, 6'd0);
      check("mism_q_empty", exp_q.size(), 0);

      // Master never goes busy: timeout 64 cycles after the request.
      bad_limit = 0;
      no_busy = 1'b1;
      push_entry(8'h03, 8'h6F, 1'b0);
      pulse_start(1'b1);
      wait_end("tmo", 500, ecyc);
      check("tmo_error", m_error, 1'b1);
      check("tmo_err_code", m_ec, 2'b10);
      check("tmo_err_index", m_ei, 6'd0);
      check("tmo_latency", ecyc - last_req_cyc, 64);
      check("tmo_q_empty", exp_q.size(), 0);
      no_busy = 1'b0;

      // Reset while entry 1's write is in flight, then a clean rerun.
      rd_base = rd_cnt;
      push_entry(8'h03, 8'h6F, 1'b1);
      push(8'hB8, 8'h0F, 8'h02);
      pulse_start(1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_mid_reached", exp_q.size(), 0);
      wait_busy(1'b1, 10);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstm_busy", m_busy, 1'b0);
      check("rstm_req", m_req, 1'b0);
      check("rstm_done", m_done, 1'b0);
      check("rstm_error", m_error, 1'b0);
      check("rstm_err_code", m_ec, 2'b00);
      check("rstm_err_index", m_ei, 6'd0);
      check("rstm_entry_cnt", m_cnt, 6'd0);
      check("rstm_rom_addr", m_rom_addr, 6'd0);
      check("rstm_dev", m_addr, 8'h00);
      check("rstm_sub", m_sub, 8'h00);
      check("rstm_data", m_wdat, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      wait_busy(1'b0, 40);
      rd_base = rd_cnt;
      push_entry(8'h03, 8'h6F, 1'b1);
      push_entry(8'h0F, 8'h02, 1'b1);
      pulse_start(1'b1);
      wait_end("rerun", 2000, ecyc);
      check("rerun_done", m_done, 1'b1);
      check("rerun_error", m_error, 1'b0);
      check("rerun_err_code", m_ec, 2'b00);
      check("rerun_entry_cnt", m_cnt, 6'd2);
      check("rerun_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
